// File: rtl/fifo_arbiter_if.sv
// Signal bundle between fifo_arbiter, its two producers, the shared FIFO and the consumer.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface fifo_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  req_a;
  logic                  req_b;
  logic [DATA_WIDTH-1:0] din_a;
  logic [DATA_WIDTH-1:0] din_b;
  logic                  ack_a;
  logic                  ack_b;
  logic                  fifo_wr;
  logic [DATA_WIDTH:0]   fifo_din;
  logic                  fifo_full;
  logic                  fifo_rd;
  logic [DATA_WIDTH:0]   fifo_dout;
  logic                  fifo_empty;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_src;
  logic                  out_ready;
  logic [CNT_WIDTH-1:0]  cnt_a;
  logic [CNT_WIDTH-1:0]  cnt_b;

  modport master (
    input  req_a, req_b, din_a, din_b, fifo_full, fifo_dout, fifo_empty, out_ready,
    output ack_a, ack_b, fifo_wr, fifo_din, fifo_rd, out_valid, out_data, out_src, cnt_a, cnt_b
  );

  modport slave (
    output req_a, req_b, din_a, din_b, fifo_full, fifo_dout, fifo_empty, out_ready,
    input  ack_a, ack_b, fifo_wr, fifo_din, fifo_rd, out_valid, out_data, out_src, cnt_a, cnt_b
  );
endinterface

// File: rtl/fifo_arbiter.sv
// Round-robin merge of two producers onto a shared FIFO, with a registered
// valid/ready output stage draining the FIFO read port.
module fifo_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic            clk,
  input logic            reset,
  fifo_arbiter_if.master bus
);
  typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;

  state_e                state_q, state_d;
  logic                  prio_q, prio_d;
  logic                  grant_b;
  logic                  wr;
  logic                  rd;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_src_q, out_src_d;
  logic [CNT_WIDTH-1:0]  cnt_a_q, cnt_a_d;
  logic [CNT_WIDTH-1:0]  cnt_b_q, cnt_b_d;

  // Write arbiter: prio_q=1 favours B when both request.
  always_comb begin
    grant_b = bus.req_b & (~bus.req_a | prio_q);
    wr      = (bus.req_a | bus.req_b) & ~bus.fifo_full;
    prio_d  = wr ? ~grant_b : prio_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (wr && !grant_b) cnt_a_d = cnt_a_q + CNT_WIDTH'(1);
    if (wr && grant_b)  cnt_b_d = cnt_b_q + CNT_WIDTH'(1);
  end

  assign bus.fifo_wr  = wr;
  assign bus.ack_a    = wr & ~grant_b;
  assign bus.ack_b    = wr & grant_b;
  assign bus.fifo_din = grant_b ? {1'b1, bus.din_b} : {1'b0, bus.din_a};

  // Read FSM: the FIFO's read data is registered, so a LOAD cycle sits between read and capture.
  always_comb begin
    state_d     = state_q;
    rd          = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    unique case (state_q)
      StIdle: begin
        rd = ~bus.fifo_empty;
        if (rd) state_d = StLoad;
      end
      StLoad: begin
        out_data_d  = bus.fifo_dout[DATA_WIDTH-1:0];
        out_src_d   = bus.fifo_dout[DATA_WIDTH];
        out_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.fifo_rd   = rd;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.cnt_a     = cnt_a_q;
  assign bus.cnt_b     = cnt_b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
    end
  end
endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: behavioural 4-deep FIFO, directed scenarios and a randomized
// run checked against a queue-based reference model.
module tb_fifo_arbiter;
  localparam int FD = 4;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  fifo_arbiter_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();
  fifo_arbiter_if #(.DATA_WIDTH(8), .CNT_WIDTH(4))  wbus ();

  fifo_arbiter #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  fifo_arbiter #(.DATA_WIDTH(8), .CNT_WIDTH(4))  dut_w (.clk(clk), .reset(reset), .bus(wbus));

  always #5 clk = ~clk;

  // Shared FIFO: registered read data, flags from occupancy, same reset as the arbiter.
  logic [8:0] fq[$];
  int         fcnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fq.delete();
      fcnt          <= 0;
      bus.fifo_dout <= '0;
    end else begin
      if (bus.fifo_rd && fq.size() > 0) bus.fifo_dout <= fq.pop_front();
      if (bus.fifo_wr && fq.size() < FD) fq.push_back(bus.fifo_din);
      fcnt <= fq.size();
    end
  end
  assign bus.fifo_full  = (fcnt == FD);
  assign bus.fifo_empty = (fcnt == 0);

  task automatic apply_reset();
    bus.req_a = 0; bus.req_b = 0; bus.out_ready = 0; wbus.req_a = 0;
    @(posedge clk);
    #1 reset = 1;
    #2 reset = 0;
  endtask

  task automatic test_reset();
    bus.req_a = 1; bus.din_a = 8'h3C;
    #2;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_data !== 8'h00) $display("FAIL rst_data got %h want 00", bus.out_data); else passed++;
    total++; if (bus.out_src !== 1'b0) $display("FAIL rst_src got %b want 0", bus.out_src); else passed++;
    total++; if (bus.cnt_a !== 16'd0 || bus.cnt_b !== 16'd0) $display("FAIL rst_cnt got %0d/%0d want 0/0", bus.cnt_a, bus.cnt_b); else passed++;
    total++; if (wbus.cnt_a !== 4'd0) $display("FAIL rst_wcnt got %0d want 0", wbus.cnt_a); else passed++;
    total++; if (bus.ack_a !== 1'b1 || bus.fifo_wr !== 1'b1) $display("FAIL rst_comb_ack got %b%b want 11", bus.ack_a, bus.fifo_wr); else passed++;
    total++; if (bus.fifo_din !== 9'h03C) $display("FAIL rst_din got %h want 03c", bus.fifo_din); else passed++;
    total++; if (bus.fifo_rd !== 1'b0) $display("FAIL rst_rd got %b want 0", bus.fifo_rd); else passed++;
    @(posedge clk); #1;
    total++; if (bus.cnt_a !== 16'd0) $display("FAIL rst_hold_cnt got %0d want 0", bus.cnt_a); else passed++;
    bus.req_a = 0;
    reset = 0;
  endtask

  task automatic test_reset_mid_hold();
    int n;
    apply_reset();
    bus.req_a = 1; bus.din_a = 8'd1; n = 0;
    for (int c = 0; c < 30 && n < 5; c++) begin
      @(negedge clk);
      if (bus.ack_a) n++;
      @(posedge clk); #1;
      if (n == 5) bus.req_a = 0; else bus.din_a = 8'(n + 1);
    end
    total++; if (n != 5) $display("FAIL midrst_fill got %0d acks want 5", n); else passed++;
    @(negedge clk);
    total++; if (bus.cnt_a !== 16'd5) $display("FAIL midrst_cnt got %0d want 5", bus.cnt_a); else passed++;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd1) $display("FAIL midrst_hold got %b/%h want 1/01", bus.out_valid, bus.out_data); else passed++;
    #1 reset = 1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 || bus.out_src !== 1'b0) $display("FAIL midrst_out got %b/%h/%b want 0/00/0", bus.out_valid, bus.out_data, bus.out_src); else passed++;
    total++; if (bus.cnt_a !== 16'd0) $display("FAIL midrst_cnt0 got %0d want 0", bus.cnt_a); else passed++;
    total++; if (bus.fifo_rd !== 1'b0) $display("FAIL midrst_rd got %b want 0", bus.fifo_rd); else passed++;
    @(posedge clk); #1 reset = 0;
  endtask

  task automatic test_single();
    logic [7:0] din_tab[3];
    logic [7:0] got[$];
    int n, cyc, rd_t, v_t;
    din_tab[0] = 8'h11; din_tab[1] = 8'h22; din_tab[2] = 8'h33;
    apply_reset();
    bus.out_ready = 1; bus.req_a = 1; bus.din_a = din_tab[0];
    n = 0; rd_t = -1; v_t = -1;
    for (cyc = 0; cyc < 40 && got.size() < 3; cyc++) begin
      @(negedge clk);
      if (bus.fifo_rd && rd_t < 0) rd_t = cyc;
      if (bus.out_valid && v_t < 0) v_t = cyc;
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(bus.out_data);
        total++; if (bus.out_src !== 1'b0) $display("FAIL single_src got %b want 0", bus.out_src); else passed++;
      end
      if (bus.ack_a) n++;
      @(posedge clk); #1;
      if (n >= 3) bus.req_a = 0; else bus.din_a = din_tab[n];
    end
    total++; if (got.size() != 3) $display("FAIL single_count got %0d want 3", got.size()); else passed++;
    for (int i = 0; i < got.size() && i < 3; i++) begin
      total++; if (got[i] !== din_tab[i]) $display("FAIL single_data[%0d] got %h want %h", i, got[i], din_tab[i]); else passed++;
    end
    total++; if (v_t - rd_t != 2) $display("FAIL single_latency got %0d want 2", v_t - rd_t); else passed++;
    total++; if (bus.cnt_a !== 16'd3) $display("FAIL single_cnt got %0d want 3", bus.cnt_a); else passed++;
  endtask

  task automatic test_contention();
    logic [8:0] got[$];
    logic [8:0] want;
    int na, nb;
    apply_reset();
    bus.out_ready = 1; bus.req_a = 1; bus.req_b = 1; bus.din_a = 8'hA0; bus.din_b = 8'hB0;
    na = 0; nb = 0;
    for (int c = 0; c < 120 && got.size() < 8; c++) begin
      @(negedge clk);
      if (bus.ack_a && bus.ack_b) begin
        total++; $display("FAIL cont_double_ack got 11 want at most one");
      end
      if (bus.out_valid && bus.out_ready) got.push_back({bus.out_src, bus.out_data});
      if (bus.ack_a) na++;
      if (bus.ack_b) nb++;
      @(posedge clk); #1;
      if (na >= 4) bus.req_a = 0; else bus.din_a = 8'hA0 + 8'(na);
      if (nb >= 4) bus.req_b = 0; else bus.din_b = 8'hB0 + 8'(nb);
    end
    total++; if (got.size() != 8) $display("FAIL cont_count got %0d want 8", got.size()); else passed++;
    for (int i = 0; i < got.size() && i < 8; i++) begin
      want = (i % 2 == 0) ? {1'b0, 8'hA0 + 8'(i / 2)} : {1'b1, 8'hB0 + 8'(i / 2)};
      total++; if (got[i] !== want) $display("FAIL cont_word[%0d] got %h want %h", i, got[i], want); else passed++;
    end
    total++; if (bus.cnt_a !== 16'd4 || bus.cnt_b !== 16'd4) $display("FAIL cont_cnt got %0d/%0d want 4/4", bus.cnt_a, bus.cnt_b); else passed++;
  endtask

  task automatic test_backpressure();
    bit seen;
    apply_reset();
    bus.req_b = 1; bus.din_b = 8'h40;
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      seen = bus.fifo_full;
      if (!seen) begin
        @(posedge clk); #1;
        if (bus.ack_b) bus.din_b = bus.din_b + 8'd1;
      end
    end
    total++; if (!seen) $display("FAIL bp_full got 0 want 1 within budget"); else passed++;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      total++; if (bus.ack_b !== 1'b0) $display("FAIL bp_ack_full got %b want 0", bus.ack_b); else passed++;
      total++; if (bus.cnt_b !== 16'd5) $display("FAIL bp_cnt_frozen got %0d want 5", bus.cnt_b); else passed++;
    end
    @(posedge clk); #1 bus.out_ready = 1;
    @(negedge clk);
    total++; if (bus.ack_b !== 1'b0 || bus.fifo_rd !== 1'b0) $display("FAIL bp_pulse got ack %b rd %b want 0 0", bus.ack_b, bus.fifo_rd); else passed++;
    @(posedge clk); #1 bus.out_ready = 0;
    @(negedge clk);
    total++; if (bus.fifo_rd !== 1'b1 || bus.ack_b !== 1'b0) $display("FAIL bp_read got rd %b ack %b want 1 0", bus.fifo_rd, bus.ack_b); else passed++;
    @(negedge clk);
    total++; if (bus.fifo_full !== 1'b0 || bus.ack_b !== 1'b1) $display("FAIL bp_resume got full %b ack %b want 0 1", bus.fifo_full, bus.ack_b); else passed++;
    @(posedge clk); #1 bus.req_b = 0;
    total++; if (bus.cnt_b !== 16'd6) $display("FAIL bp_cnt_after got %0d want 6", bus.cnt_b); else passed++;
  endtask

  task automatic test_stall();
    int n, nrd;
    apply_reset();
    bus.req_a = 1; bus.din_a = 8'h5A; n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      if (bus.ack_a) n++;
      @(posedge clk); #1;
      if (n >= 2) bus.req_a = 0; else bus.din_a = 8'h6B;
    end
    for (int c = 0; c < 10 && !bus.out_valid; c++) @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A) $display("FAIL stall_hold got %b/%h want 1/5a", bus.out_valid, bus.out_data); else passed++;
      total++; if (bus.fifo_rd !== 1'b0) $display("FAIL stall_rd got %b want 0", bus.fifo_rd); else passed++;
    end
    @(posedge clk); #1 bus.out_ready = 1;
    @(posedge clk); #1 bus.out_ready = 0;
    nrd = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.fifo_rd) nrd++;
    end
    total++; if (nrd != 1) $display("FAIL stall_reads got %0d want 1", nrd); else passed++;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h6B) $display("FAIL stall_next got %b/%h want 1/6b", bus.out_valid, bus.out_data); else passed++;
    total++; if (bus.fifo_empty !== 1'b1) $display("FAIL stall_empty got %b want 1", bus.fifo_empty); else passed++;
  endtask

  task automatic test_wrap();
    apply_reset();
    wbus.req_a = 1; wbus.din_a = 8'h77;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      total++; if (wbus.ack_a !== 1'b1) $display("FAIL wrap_ack[%0d] got %b want 1", i, wbus.ack_a); else passed++;
    end
    @(posedge clk); #1;
    total++; if (wbus.cnt_a !== 4'd0) $display("FAIL wrap_zero got %0d want 0", wbus.cnt_a); else passed++;
    @(posedge clk); #1 wbus.req_a = 0;
    total++; if (wbus.cnt_a !== 4'd1) $display("FAIL wrap_one got %0d want 1", wbus.cnt_a); else passed++;
  endtask

  // Reference: arbitration from the request/priority rules, expected words in write order,
  // and the output stage as "free / word in flight / word presented".
  task automatic test_random();
    bit         ra, rb, mprio, wr, gb, erd;
    logic [7:0] da, db;
    logic [15:0] ma, mb;
    logic [8:0] expq[$];
    logic [8:0] exp_w;
    int         stage;
    apply_reset();
    ra = 0; rb = 0; mprio = 0; ma = 0; mb = 0; stage = 0; da = 0; db = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      wr  = (ra || rb) && !bus.fifo_full;
      gb  = rb && (!ra || mprio);
      erd = !bus.fifo_empty && stage == 0;
      total++; if (bus.ack_a !== (wr && !gb) || bus.ack_b !== (wr && gb)) $display("FAIL rnd_ack c%0d got %b%b want %b%b", c, bus.ack_a, bus.ack_b, wr && !gb, wr && gb); else passed++;
      if (wr) begin
        exp_w = gb ? {1'b1, db} : {1'b0, da};
        total++; if (bus.fifo_din !== exp_w) $display("FAIL rnd_din c%0d got %h want %h", c, bus.fifo_din, exp_w); else passed++;
      end
      total++; if (bus.cnt_a !== ma || bus.cnt_b !== mb) $display("FAIL rnd_cnt c%0d got %0d/%0d want %0d/%0d", c, bus.cnt_a, bus.cnt_b, ma, mb); else passed++;
      total++; if (bus.fifo_rd !== erd || bus.out_valid !== (stage == 2)) $display("FAIL rnd_rdvalid c%0d got %b%b want %b%b", c, bus.fifo_rd, bus.out_valid, erd, stage == 2); else passed++;
      if (stage == 2 && bus.out_ready) begin
        exp_w = (expq.size() > 0) ? expq.pop_front() : 9'h1FF;
        total++; if ({bus.out_src, bus.out_data} !== exp_w) $display("FAIL rnd_out c%0d got %h want %h", c, {bus.out_src, bus.out_data}, exp_w); else passed++;
      end
      if (wr) begin
        expq.push_back(gb ? {1'b1, db} : {1'b0, da});
        mprio = !gb;
        if (gb) mb = mb + 16'd1; else ma = ma + 16'd1;
      end
      if (stage == 2 && bus.out_ready) stage = 0;
      else if (stage == 1) stage = 2;
      else if (stage == 0 && erd) stage = 1;
      @(posedge clk); #1;
      if (!ra || (wr && !gb)) begin ra = ($urandom_range(0, 3) != 0); da = 8'($urandom); end
      if (!rb || (wr && gb))  begin rb = ($urandom_range(0, 3) != 0); db = 8'($urandom); end
      bus.req_a = ra; bus.din_a = da; bus.req_b = rb; bus.din_b = db;
      bus.out_ready = ($urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    clk = 0; reset = 0; total = 0; passed = 0;
    bus.req_a = 0; bus.req_b = 0; bus.din_a = 0; bus.din_b = 0; bus.out_ready = 0;
    wbus.req_a = 0; wbus.req_b = 0; wbus.din_a = 0; wbus.din_b = 0; wbus.out_ready = 1;
    wbus.fifo_full = 0; wbus.fifo_empty = 1; wbus.fifo_dout = '0;
    #1 reset = 1;
    test_reset();
    test_reset_mid_hold();
    test_single();
    test_contention();
    test_backpressure();
    test_stall();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fifo_arbiter.md
# fifo_arbiter

Round-robin controller for the shared 8-bit FIFO. It merges two producer streams (A and B) onto the FIFO write port and tags each word with its source. It drains the FIFO read port into a registered valid/ready output stage for a single consumer, for example a UART or PS/2 transmitter. The block sits between the producers, one FIFO instance (`fifo` with DATA_WIDTH+1 data width) and the consumer.

## Interface
- DATA_WIDTH, 8, payload width per producer; the FIFO is instantiated DATA_WIDTH+1 wide.
- CNT_WIDTH, 16, width of the per-source accepted-word counters.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_a / req_b  in  1  producer has a word; must stay high with din stable until ack.
- din_a / din_b  in  DATA_WIDTH  producer payload.
- ack_a / ack_b  out  1  combinational; word accepted this cycle.
- fifo_wr  out  1  combinational FIFO write strobe.
- fifo_din  out  DATA_WIDTH+1  {src, payload}; src=0 for A, 1 for B.
- fifo_full  in  1  FIFO full flag.
- fifo_rd  out  1  combinational FIFO read strobe.
- fifo_dout  in  DATA_WIDTH+1  FIFO registered read data, valid the cycle after fifo_rd.
- fifo_empty  in  1  FIFO empty flag.
- out_valid  out  1  registered; out_data/out_src hold a word.
- out_data  out  DATA_WIDTH  registered payload.
- out_src  out  1  registered source tag.
- out_ready  in  1  consumer accepts the word when out_valid and out_ready are both high.
- cnt_a / cnt_b  out  CNT_WIDTH  registered count of words accepted from each source; wraps modulo 2^CNT_WIDTH.

## Operation
- Write arbiter, combinational grant plus a 1-bit registered priority pointer `prio` (0 favours A).
  - One requester high: it is granted.
  - Both high: the source selected by `prio` is granted.
  - fifo_wr = (req_a|req_b) & ~fifo_full. ack_x = grant_x & fifo_wr. fifo_din is driven from the granted source.
  - On each accepted write, `prio` is set to the non-granted source.
  - When fifo_full is high there is no write, no ack, `prio` is unchanged and requests stay pending.
  - cnt_x increments on each ack_x.
- Read FSM, states IDLE, LOAD, HOLD:
  - IDLE: fifo_rd = ~fifo_empty. If fifo_rd is high, go to LOAD.
  - LOAD: fifo_rd=0. Capture out_data <= fifo_dout[DATA_WIDTH-1:0] and out_src <= fifo_dout[DATA_WIDTH], set out_valid <= 1, go to HOLD.
  - HOLD: out_valid=1 with data stable. When out_ready is high, clear out_valid and go to IDLE.
  - fifo_rd is never asserted outside IDLE.
- Simultaneous FIFO write and read in the same cycle are independent and both permitted. The arbiter relies on the FIFO's own full/empty flags.
- Reset (any time, including mid-HOLD or during a granted write):
  - state=IDLE, prio=0, out_valid=0, out_data=0, out_src=0, cnt_a=cnt_b=0.
  - Combinational outputs follow their inputs, so ack and fifo_rd still depend on req and the flags.
  - A word held in HOLD at reset is discarded. The FIFO shares the same reset.

## Timing
- Write: ack in the same cycle as req when not full; one word per cycle maximum; a producer holding req sustains one word per cycle if it is the only requester.
- Both requesters continuously active: strict alternation A,B,A,B… starting with `prio`.
- Read latency: fifo_rd at cycle T, LOAD at T+1, out_valid high from T+2.
- Read throughput: one word per 3 cycles with out_ready tied high (IDLE→LOAD→HOLD→IDLE).
- out_valid falls the cycle after an out_ready handshake. The next fifo_rd can occur in that same cycle, since the FSM is in IDLE.
- Counter wrap: at 2^CNT_WIDTH-1, the next ack gives 0.

## Test plan
- Reset while in HOLD with out_valid=1, cnt_a=5: all registered outputs read 0 in the same cycle; state returns to IDLE.
- Single producer: req_a high, din_a=0x11,0x22,0x33 on successive acks; out_ready=1 → out_data 0x11,0x22,0x33 with out_src=0 and cnt_a=3. First out_valid is exactly 2 cycles after the first fifo_rd.
- Contention: req_a and req_b held together, A sends 0xA0..0xA3 and B sends 0xB0..0xB3 → FIFO order A0,B0,A1,B1,A2,B2,A3,B3; out_src alternates 0,1.
- Full back-pressure: out_ready=0 until the FIFO is full, with req_b high → ack_b=0 and cnt_b frozen. Raising out_ready causes one read; the next cycle after fifo_full drops gives ack_b=1.
- Consumer stall: out_ready=0 for 10 cycles in HOLD → out_data stable, fifo_rd=0 throughout. Pulsing out_ready for one cycle gives exactly one word consumed.
- Counter wrap with CNT_WIDTH=4: 17 acks from A → cnt_a=1.
